// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the rysy RV32I core: boot bubble, load/store
// handshake with timeout, control-transfer flush. Optional perf counters: CTRL_SEQ_PERF_CNT_EN.
module ctrl_seq #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
`ifdef CTRL_SEQ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             b,
  input  logic             mem_ready,
  input  logic             hold,
  output logic             reg_wr,
  output logic             we,
  output logic             mem_req,
  output logic [1:0]       pc_sel,
  output logic             mem_sel,
  output logic [1:0]       inst_sel,
  output logic             err,
  output logic [2:0]       state
`ifdef CTRL_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cyc
`endif
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_EXEC  = 3'd1,
    S_LWAIT = 3'd2,
    S_LWB   = 3'd3,
    S_SWAIT = 3'd4,
    S_FLUSH = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  typedef enum logic [1:0] {PC_P4 = 2'd0, PC_ALU = 2'd1, PC_OLD = 2'd2} pc_sel_t;
  typedef enum logic [1:0] {INST_MEM = 2'd0, INST_NOP = 2'd1, INST_OLD = 2'd2} inst_sel_t;
  typedef enum logic {MEM_PC = 1'b0, MEM_ALU = 1'b1} mem_sel_t;

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OP_IMM = 5'b00100,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011
  } opcode_t;

  localparam logic              TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_BOOT;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_cnt;
    reg_wr    = 1'b0;
    we        = 1'b0;
    mem_req   = 1'b0;
    pc_sel    = PC_P4;
    mem_sel   = MEM_PC;
    inst_sel  = INST_MEM;
    err       = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        inst_sel  = INST_NOP;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (hold) begin
          pc_sel   = PC_OLD;
          inst_sel = INST_OLD;
        end else begin
          case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI: reg_wr = 1'b1;
            OPC_JAL, OPC_JALR: begin
              reg_wr    = 1'b1;
              pc_sel    = PC_ALU;
              inst_sel  = INST_NOP;
              state_nxt = S_FLUSH;
            end
            OPC_BRANCH: begin
              if (b) begin
                pc_sel    = PC_ALU;
                inst_sel  = INST_NOP;
                state_nxt = S_FLUSH;
              end
            end
            OPC_STORE, OPC_LOAD: begin
              mem_req  = 1'b1;
              we       = (opcode == OPC_STORE);
              mem_sel  = MEM_ALU;
              pc_sel   = PC_OLD;
              inst_sel = INST_OLD;
              if (mem_ready) begin
                state_nxt = (opcode == OPC_STORE) ? S_FLUSH : S_LWB;
              end else begin
                state_nxt = (opcode == OPC_STORE) ? S_SWAIT : S_LWAIT;
                wait_nxt  = WAIT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      S_LWAIT, S_SWAIT: begin
        mem_req  = 1'b1;
        we       = (state_q == S_SWAIT);
        mem_sel  = MEM_ALU;
        pc_sel   = PC_OLD;
        inst_sel = INST_OLD;
        // Ready on the limit cycle wins over the timeout; the counter saturates.
        if (mem_ready) begin
          state_nxt = (state_q == S_SWAIT) ? S_FLUSH : S_LWB;
          wait_nxt  = '0;
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LIMIT)) begin
          state_nxt = S_ERR;
        end else if (wait_cnt != '1) begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_LWB: begin
        reg_wr    = 1'b1;
        inst_sel  = INST_NOP;
        state_nxt = S_EXEC;
      end
      S_FLUSH: begin
        inst_sel  = INST_NOP;
        state_nxt = S_EXEC;
      end
      S_ERR: begin
        err      = 1'b1;
        pc_sel   = PC_OLD;
        inst_sel = INST_NOP;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  assign state = state_q;

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic retire_inc, stall_inc;

  assign retire_inc = ((state_q == S_EXEC) && !hold) || (state_q == S_LWB);
  assign stall_inc  = (state_q == S_LWAIT) || (state_q == S_SWAIT) ||
                      (state_q == S_FLUSH) || ((state_q == S_EXEC) && hold);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired   <= '0;
      stall_cyc <= '0;
    end else begin
      if (retire_inc && (retired != '1))  retired   <= retired + CNT_W'(1);
      if (stall_inc && (stall_cyc != '1)) stall_cyc <= stall_cyc + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Parametrised multi-cycle control sequencer for the rysy RV32I core. It is the successor to the single-bit load-phase controller.
- Replaces the implicit next_nop/load_phase flops with an explicit state machine.
- Supports variable-latency data memory through a req/ready handshake, a configurable wait timeout and a pipeline hold input.
- Drives reg_wr, we and the select lines of the PC/address muxes and instruction management; decode of imm/alu/cmp selects stays combinational elsewhere.

Parameters:
- MAX_WAIT, 15, max cycles a LOAD/STORE may wait for mem_ready before error; 0 = no timeout.
- WAIT_W, 4, wait counter width; must satisfy 2^WAIT_W > MAX_WAIT.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  5  instr[6:2] of current instruction.
- b  in  1  branch-taken from cmp.
- mem_ready  in  1  data memory completes the access this cycle.
- hold  in  1  freeze request, sampled in S_EXEC only.
- reg_wr  out  1  register file write enable.
- we  out  1  data memory write enable.
- mem_req  out  1  data access request.
- pc_sel  out  2  `PC_P4`/`PC_ALU`/`PC_OLD`, rysy_pkg.vh encodings.
- mem_sel  out  1  `MEM_PC`/`MEM_ALU`.
- inst_sel  out  2  `INST_MEM`/`INST_NOP`/`INST_OLD`.
- err  out  1  sticky memory-timeout error.
- state  out  3  current state, for debug.

Behaviour:
- States: S_BOOT=0, S_EXEC=1, S_LWAIT=2, S_LWB=3, S_SWAIT=4, S_FLUSH=5, S_ERR=6. State and counter registered; outputs are a combinational function of state, opcode, b, mem_ready and hold.
- Reset (rst=0, async): state=S_BOOT, wait_cnt=0, err=0.
- Outputs while rst=0 or in S_BOOT: reg_wr=0, we=0, mem_req=0, pc_sel=PC_P4, mem_sel=MEM_PC, inst_sel=INST_NOP.
- S_BOOT: lasts exactly 1 cycle, then S_EXEC. This prevents the first instruction executing twice.
- Defaults in every state unless listed below: reg_wr=0, we=0, mem_req=0, pc_sel=PC_P4, mem_sel=MEM_PC, inst_sel=INST_MEM.
- S_EXEC, hold=1: pc_sel=PC_OLD, inst_sel=INST_OLD, no writes, stay. hold has priority over opcode.
- S_EXEC, OP/OP_IMM/LUI: reg_wr=1, stay.
- S_EXEC, JAL/JALR: reg_wr=1, pc_sel=PC_ALU, inst_sel=INST_NOP, next S_FLUSH.
- S_EXEC, BRANCH, b=1: pc_sel=PC_ALU, inst_sel=INST_NOP, next S_FLUSH.
- S_EXEC, BRANCH, b=0: defaults, stay.
- S_EXEC, STORE: mem_req=1, we=1, mem_sel=MEM_ALU, pc_sel=PC_OLD, inst_sel=INST_OLD. mem_ready=1 -> S_FLUSH; otherwise -> S_SWAIT with wait_cnt=1.
- S_EXEC, LOAD: mem_req=1, mem_sel=MEM_ALU, pc_sel=PC_OLD, inst_sel=INST_OLD. mem_ready=1 -> S_LWB; otherwise -> S_LWAIT with wait_cnt=1.
- S_EXEC, any other opcode: treated as NOP (defaults), stay.
- S_SWAIT: same outputs as the STORE cycle. mem_ready=1 -> S_FLUSH, wait_cnt=0. Else if MAX_WAIT!=0 and wait_cnt==MAX_WAIT -> S_ERR. Else wait_cnt+1.
- S_LWAIT: same outputs as the LOAD cycle. mem_ready=1 -> S_LWB. Timeout rule identical to S_SWAIT.
- Timeout arithmetic: wait_cnt never wraps. mem_ready on the same cycle as wait_cnt==MAX_WAIT counts as success.
- S_LWB: reg_wr=1, mem_sel=MEM_PC, pc_sel=PC_P4, inst_sel=INST_NOP, next S_EXEC. Data is captured by rd_mux.
- S_FLUSH: inst_sel=INST_NOP, pc_sel=PC_P4, no writes, next S_EXEC. This is exactly one bubble after any taken control transfer or store.
- S_ERR: err=1, all enables 0, pc_sel=PC_OLD, inst_sel=INST_NOP. Terminal until reset.
- Reset asserted mid-access: outputs take reset values immediately, without waiting for a clock edge; no partial write completes after rst falls.
- Latency: ALU/LUI 1 cycle; taken jump/branch 2; store 2+N wait; load 2+N wait.

Optional Feature:
- Macro: CTRL_SEQ_PERF_CNT_EN.
- Defined: adds outputs retired[CNT_W] and stall_cyc[CNT_W], both reset to 0 and saturating at all-ones.
  - retired increments on every S_EXEC cycle with hold=0 that leaves or stays in S_EXEC, and on S_LWB.
  - stall_cyc increments each cycle in S_LWAIT, S_SWAIT, S_FLUSH, or S_EXEC with hold=1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Release rst, opcode=OP for 3 cycles -> state 0,1,1; reg_wr=0 in S_BOOT, then 1,1; inst_sel NOP then MEM.
- opcode=LOAD, mem_ready low 3 cycles then high -> S_EXEC, LWAIT x3, LWB. mem_req=1 for 4 cycles; reg_wr=1 only in LWB; pc_sel=PC_OLD throughout the wait.
- opcode=STORE, mem_ready=1 immediately -> we=1 for 1 cycle, then S_FLUSH with inst_sel=NOP, then S_EXEC.
- MAX_WAIT=15, LOAD with mem_ready held 0 -> S_ERR entered on the 16th wait-state edge, err=1 and stays 1; rst pulse clears it to 0.
- BRANCH b=1 then b=0 -> first gives pc_sel=PC_ALU plus FLUSH; second gives pc_sel=PC_P4, no bubble. hold=1 with opcode=JAL -> reg_wr=0, pc_sel=PC_OLD.
- rst driven low mid-S_LWAIT between clock edges -> mem_req, reg_wr and we drop to 0 with no clock edge; state=S_BOOT.
